// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit 7-segment scan controller with per-slot blanking.
// Each slot blanks every common, then drives one latched digit code.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] d0,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  input  logic [6:0] d3,
  input  logic [6:0] d4,
  input  logic [6:0] d5,
  input  logic [6:0] d6,
  input  logic [6:0] d7,
  input  logic [7:0] digit_mask,
  output logic [6:0] seg,
  output logic [7:0] com,
  output logic [2:0] idx,
  output logic       frame_start
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - BLANK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [7:0]      com_q, com_d;
  logic            fs_q, fs_d;
  logic [6:0]      d_arr [8];

  always_comb begin
    d_arr[0] = d0;
    d_arr[1] = d1;
    d_arr[2] = d2;
    d_arr[3] = d3;
    d_arr[4] = d4;
    d_arr[5] = d5;
    d_arr[6] = d6;
    d_arr[7] = d7;
  end

  // State register; reset aborts any slot in progress on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      seg_q   <= 7'd0;
      com_q   <= 8'hFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
      fs_q    <= fs_d;
    end
  end

  // Next-state logic: dropping en always returns to IDLE, so no partial slot completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so seg and com change on the same edge.
  always_comb begin
    seg_d = seg_q;
    com_d = 8'hFF;
    fs_d  = 1'b0;
    case (state_d)
      IDLE: begin
        seg_d = 7'd0;
      end
      BLANK: begin
        seg_d = 7'd0;
        fs_d  = (state_q != BLANK) && (idx_d == 3'd0);
      end
      DRIVE: begin
        if (state_q == BLANK) begin
          seg_d = d_arr[idx_d];
        end else begin
          seg_d = seg_q;
        end
        if (digit_mask[idx_d]) begin
          com_d = ~(8'd1 << idx_d);
        end else begin
          com_d = 8'hFF;
        end
      end
      default: begin
        seg_d = 7'd0;
      end
    endcase
  end

  assign seg         = seg_q;
  assign com         = com_q;
  assign idx         = idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model, directed table and corner sequences.
module tb_seg_scan_ctrl;
  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 8 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [6:0] d [8];
  logic [7:0] digit_mask;
  logic [6:0] seg;
  logic [7:0] com;
  logic [2:0] idx;
  logic       frame_start;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .digit_mask(digit_mask),
    .seg(seg), .com(com), .idx(idx), .frame_start(frame_start)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  // Reference model: position within the frame since the scan was (re)started.
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [6:0] m_latch = 7'd0;
  logic [2:0] e_idx;
  logic [7:0] e_com;
  logic [6:0] e_seg;
  logic       e_fs;
  bit         started = 1'b0;
  logic [6:0] prev_seg = 7'd0;

  always @(posedge clk) begin : model
    int pos_n;
    int slot;
    int off;
    logic [6:0] lat_n;
    lat_n = m_latch;
    if (rst || !en) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      e_idx    <= 3'd0;
      e_com    <= 8'hFF;
      e_seg    <= 7'd0;
      e_fs     <= 1'b0;
    end else begin
      pos_n = m_active ? (m_pos + 1) % FRAME : 0;
      slot  = pos_n / CLK_DIV;
      off   = pos_n % CLK_DIV;
      if (off == BLANK_CYC) lat_n = d[slot];
      m_active <= 1'b1;
      m_pos    <= pos_n;
      m_latch  <= lat_n;
      e_idx    <= 3'(slot);
      e_fs     <= (pos_n == 0);
      if (off < BLANK_CYC) begin
        e_com <= 8'hFF;
        e_seg <= 7'd0;
      end else begin
        e_seg <= lat_n;
        e_com <= digit_mask[slot] ? ~(8'd1 << slot) : 8'hFF;
      end
    end
    started <= 1'b1;
  end

  // Every-cycle comparison against the model plus the overlap and ghosting invariants.
  always @(negedge clk) begin
    if (started) begin
      chk("model_idx", 32'(idx), 32'(e_idx));
      chk("model_com", 32'(com), 32'(e_com));
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_fs", 32'(frame_start), 32'(e_fs));
      chk("one_cold", 32'($countones(~com) <= 1), 32'd1);
      chk("ghost", 32'(!(prev_seg != 7'd0 && seg != 7'd0 && seg != prev_seg && com != 8'hFF)), 32'd1);
      prev_seg <= seg;
    end
  end

  typedef struct {
    int         c;
    logic [2:0] idx;
    logic [7:0] com;
    logic [6:0] seg;
    logic       fs;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go(input int t);
    while (cyc < t) tick();
  endtask

  task automatic restart();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    cyc = -1;
  endtask

  task automatic load_digits();
    d[0] = 7'h7E; d[1] = 7'h30; d[2] = 7'h6D; d[3] = 7'h79;
    d[4] = 7'h33; d[5] = 7'h5B; d[6] = 7'h5F; d[7] = 7'h70;
  endtask

  initial begin
    tbl[0]  = '{0,  3'd0, 8'hFF, 7'h00, 1'b1};
    tbl[1]  = '{1,  3'd0, 8'hFF, 7'h00, 1'b0};
    tbl[2]  = '{2,  3'd0, 8'hFE, 7'h7E, 1'b0};
    tbl[3]  = '{7,  3'd0, 8'hFE, 7'h7E, 1'b0};
    tbl[4]  = '{8,  3'd1, 8'hFF, 7'h00, 1'b0};
    tbl[5]  = '{10, 3'd1, 8'hFD, 7'h30, 1'b0};
    tbl[6]  = '{26, 3'd3, 8'hF7, 7'h79, 1'b0};
    tbl[7]  = '{42, 3'd5, 8'hDF, 7'h5B, 1'b0};
    tbl[8]  = '{50, 3'd6, 8'hBF, 7'h5F, 1'b0};
    tbl[9]  = '{63, 3'd7, 8'h7F, 7'h70, 1'b0};
    tbl[10] = '{64, 3'd0, 8'hFF, 7'h00, 1'b1};
    tbl[11] = '{66, 3'd0, 8'hFE, 7'h7E, 1'b0};

    rst = 1'b1; en = 1'b0; digit_mask = 8'hFF;
    load_digits();
    repeat (3) @(negedge clk);
    chk("reset_com", 32'(com), 32'hFF);
    chk("reset_seg", 32'(seg), 32'h0);
    chk("reset_idx", 32'(idx), 32'h0);
    chk("reset_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_com", 32'(com), 32'hFF);

    // Basic frame against the directed table.
    en = 1'b1;
    cyc = -1;
    for (int c = 0; c <= 66; c++) begin
      tick();
      for (int k = 0; k < 12; k++) begin
        if (tbl[k].c == cyc) begin
          chk("tbl_idx", 32'(idx), 32'(tbl[k].idx));
          chk("tbl_com", 32'(com), 32'(tbl[k].com));
          chk("tbl_seg", 32'(seg), 32'(tbl[k].seg));
          chk("tbl_fs", 32'(frame_start), 32'(tbl[k].fs));
        end
      end
    end

    // Masking: slots 1 and 3 stay dark, timing unchanged.
    digit_mask = 8'b1111_0101;
    restart();
    go(10); chk("mask_s1_com", 32'(com), 32'hFF); chk("mask_s1_idx", 32'(idx), 32'd1);
    go(18); chk("mask_s2_com", 32'(com), 32'hFB); chk("mask_s2_seg", 32'(seg), 32'h6D);
    go(26); chk("mask_s3_com", 32'(com), 32'hFF); chk("mask_s3_idx", 32'(idx), 32'd3);
    go(64); chk("mask_frame_fs", 32'(frame_start), 32'd1);
    digit_mask = 8'hFF;

    // Data hold: d2 changes mid-drive.
    restart();
    go(21); d[2] = 7'h7F;
    go(23); chk("hold_seg", 32'(seg), 32'h6D);
    go(24); chk("hold_end_seg", 32'(seg), 32'h00); chk("hold_end_idx", 32'(idx), 32'd3);
    go(82); chk("hold_next_seg", 32'(seg), 32'h7F); chk("hold_next_idx", 32'(idx), 32'd2);
    load_digits();

    // Disable mid-slot 5 and re-enable.
    restart();
    go(44); en = 1'b0;
    tick();
    chk("dis_com", 32'(com), 32'hFF); chk("dis_seg", 32'(seg), 32'h0); chk("dis_idx", 32'(idx), 32'h0);
    en = 1'b1;
    tick();
    chk("reen_fs", 32'(frame_start), 32'd1); chk("reen_idx", 32'(idx), 32'd0);
    tick(); tick();
    chk("reen_com", 32'(com), 32'hFE); chk("reen_seg", 32'(seg), 32'h7E);

    // Synchronous reset during slot 4 drive.
    restart();
    go(36); rst = 1'b1;
    tick();
    chk("srst_com", 32'(com), 32'hFF); chk("srst_seg", 32'(seg), 32'h0);
    chk("srst_idx", 32'(idx), 32'h0); chk("srst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;
    tick();
    chk("srst_fs_after", 32'(frame_start), 32'd1); chk("srst_com_after", 32'(com), 32'hFF);
    tick(); tick();
    chk("srst_drive", 32'(com), 32'hFE);

    // Randomized stimulus, checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      digit_mask = 8'($urandom);
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 7)] = 7'($urandom);
      en  = ($urandom_range(0, 59) != 0);
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
